// File: rtl/id_stage_if.sv
// IF/WB-facing inputs and ID/EX-facing outputs of the decode stage.
// The decode stage is the slave. The surrounding pipeline, or a bench, is the master.
interface id_stage_if;
    logic        valid_if;
    logic [31:0] IR_if;
    logic [31:0] NPC_if;
    logic        stall_in;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Imm;
    logic [31:0] NPC_id;
    logic [31:0] IR_id;
    logic        valid_id;
    logic [4:0]  dst_id;
    logic        we_id;
    logic        halted;
    logic        stall_if;

    modport master (
        output valid_if, IR_if, NPC_if, stall_in, flush, wb_en, wb_addr, wb_data,
        input  A, B, Imm, NPC_id, IR_id, valid_id, dst_id, we_id, halted, stall_if
    );

    modport slave (
        input  valid_if, IR_if, NPC_if, stall_in, flush, wb_en, wb_addr, wb_data,
        output A, B, Imm, NPC_id, IR_id, valid_id, dst_id, we_id, halted, stall_if
    );
endinterface

// File: rtl/id_stage.sv
// MIPS32-style instruction decode stage: register file with WB bypass, decode,
// load-use hazard detection and the ID/EX pipeline register.
module id_stage #(
    parameter logic [31:0] NOP_IR = 32'h0000_0000,
    parameter logic [5:0]  HLT_OP = 6'b111111
) (
    input logic clk,
    input logic rst,
    id_stage_if.slave bus
);
    localparam logic [5:0] OP_LW    = 6'b111000;
    localparam logic [5:0] OP_SW    = 6'b111001;
    localparam logic [5:0] OP_BEQZ  = 6'b110100;
    localparam logic [5:0] OP_BNEQZ = 6'b110101;

    typedef enum logic [2:0] {
        C_RR, C_RIMM, C_LW, C_SW, C_BR, C_HLT, C_UND
    } op_class_e;

    typedef enum logic {S_RUN, S_HALT} state_e;

    state_e      state;
    op_class_e   cls;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd;
    logic [4:0]  dec_dst;
    logic        dec_we;
    logic        rt_src;
    logic [31:0] rd_a, rd_b;
    logic        lu;
    logic        capture;
    logic        bubble;
    logic [31:0] rf [32];

    assign opcode = bus.IR_if[31:26];
    assign rs     = bus.IR_if[25:21];
    assign rt     = bus.IR_if[20:16];
    assign rd     = bus.IR_if[15:11];

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        cls = C_UND;
        case (opcode)
            OP_LW:           cls = C_LW;
            OP_SW:           cls = C_SW;
            OP_BEQZ, OP_BNEQZ: cls = C_BR;
            HLT_OP:          cls = C_HLT;
            default:         if (!opcode[5]) cls = opcode[4] ? C_RIMM : C_RR;
        endcase
    end

    always_comb begin
        dec_dst = 5'd0;
        dec_we  = 1'b0;
        case (cls)
            C_RR: begin
                dec_dst = rd;
                dec_we  = 1'b1;
            end
            C_RIMM, C_LW: begin
                dec_dst = rt;
                dec_we  = 1'b1;
            end
            default: begin
                dec_dst = 5'd0;
                dec_we  = 1'b0;
            end
        endcase
    end

    assign rt_src = (cls == C_RR) || (cls == C_SW);

    // The WB value written on this edge must also be the operand that ID/EX captures.
    always_comb begin
        rd_a = (rs == 5'd0) ? 32'd0 : rf[rs];
        rd_b = (rt == 5'd0) ? 32'd0 : rf[rt];
        if (bus.wb_en && bus.wb_addr != 5'd0 && bus.wb_addr == rs) rd_a = bus.wb_data;
        if (bus.wb_en && bus.wb_addr != 5'd0 && bus.wb_addr == rt) rd_b = bus.wb_data;
    end

    assign lu = bus.valid_id && (bus.IR_id[31:26] == OP_LW) && (bus.dst_id != 5'd0)
             && bus.valid_if
             && ((bus.dst_id == rs) || (rt_src && bus.dst_id == rt));

    assign capture = !bus.flush && !bus.stall_in && (state == S_RUN) && !lu && bus.valid_if;
    assign bubble  = bus.flush || (!bus.stall_in && !capture);

    assign bus.stall_if = bus.stall_in || lu || (state == S_HALT);
    assign bus.halted   = (state == S_HALT);

    // NOTE: this memory is reset on purpose, because software relies on every register starting at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
        end else if (bus.wb_en && bus.wb_addr != 5'd0) begin
            rf[bus.wb_addr] <= bus.wb_data;
        end
    end

    // NOTE: pipeline state uses non-blocking assignments, so each flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_RUN;
            bus.A        <= 32'd0;
            bus.B        <= 32'd0;
            bus.Imm      <= 32'd0;
            bus.NPC_id   <= 32'd0;
            bus.IR_id    <= NOP_IR;
            bus.valid_id <= 1'b0;
            bus.dst_id   <= 5'd0;
            bus.we_id    <= 1'b0;
        end else if (capture) begin
            bus.A        <= rd_a;
            bus.B        <= rd_b;
            bus.Imm      <= {{16{bus.IR_if[15]}}, bus.IR_if[15:0]};
            bus.NPC_id   <= bus.NPC_if;
            bus.IR_id    <= bus.IR_if;
            bus.valid_id <= 1'b1;
            bus.dst_id   <= dec_dst;
            bus.we_id    <= dec_we;
            if (cls == C_HLT) state <= S_HALT;
        end else if (bubble) begin
            bus.A        <= 32'd0;
            bus.B        <= 32'd0;
            bus.Imm      <= 32'd0;
            bus.NPC_id   <= 32'd0;
            bus.IR_id    <= NOP_IR;
            bus.valid_id <= 1'b0;
            bus.dst_id   <= 5'd0;
            bus.we_id    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// Directed, table-driven bench for id_stage, plus hand-written async-reset sequences.
module tb_id_stage;
    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct {
        logic        valid;
        logic [31:0] ir;
        logic [31:0] npc;
        logic        stall;
        logic        flush;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
    } in_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] npc;
        logic [31:0] ir;
        logic        valid;
        logic [4:0]  dst;
        logic        we;
        logic        halted;
        logic        stall_if;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t tv[$];

    id_stage_if bus();

    id_stage dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic in_t vi(input logic v, input logic [31:0] ir, input logic [31:0] npc,
                               input logic st, input logic fl, input logic we,
                               input logic [4:0] wa, input logic [31:0] wd);
        in_t r;
        r.valid = v; r.ir = ir; r.npc = npc; r.stall = st; r.flush = fl;
        r.wb_en = we; r.wb_addr = wa; r.wb_data = wd;
        return r;
    endfunction

    function automatic exp_t ve(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                                input logic [31:0] npc, input logic [31:0] ir, input logic v,
                                input logic [4:0] dst, input logic we, input logic h, input logic s);
        exp_t r;
        r.a = a; r.b = b; r.imm = imm; r.npc = npc; r.ir = ir; r.valid = v;
        r.dst = dst; r.we = we; r.halted = h; r.stall_if = s;
        return r;
    endfunction

    function automatic exp_t bub(input logic h, input logic s);
        return ve(32'd0, 32'd0, 32'd0, 32'd0, NOP, 1'b0, 5'd0, 1'b0, h, s);
    endfunction

    task automatic add(input in_t i, input exp_t e);
        vec_t v;
        v.i = i;
        v.e = e;
        tv.push_back(v);
    endtask

    task automatic drive(input in_t i);
        bus.valid_if = i.valid;
        bus.IR_if    = i.ir;
        bus.NPC_if   = i.npc;
        bus.stall_in = i.stall;
        bus.flush    = i.flush;
        bus.wb_en    = i.wb_en;
        bus.wb_addr  = i.wb_addr;
        bus.wb_data  = i.wb_data;
    endtask

    task automatic check_outs(input string tag, input exp_t e);
        check({tag, ".A"},        bus.A,                e.a);
        check({tag, ".B"},        bus.B,                e.b);
        check({tag, ".Imm"},      bus.Imm,              e.imm);
        check({tag, ".NPC_id"},   bus.NPC_id,           e.npc);
        check({tag, ".IR_id"},    bus.IR_id,            e.ir);
        check({tag, ".valid_id"}, 32'(bus.valid_id),    32'(e.valid));
        check({tag, ".dst_id"},   32'(bus.dst_id),      32'(e.dst));
        check({tag, ".we_id"},    32'(bus.we_id),       32'(e.we));
        check({tag, ".halted"},   32'(bus.halted),      32'(e.halted));
    endtask

    initial begin
        // WB r5=7, then the basic ALU case and the bypass / r0 rules
        add(vi(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h7), bub(1'b0, 1'b0));
        add(vi(1'b1, 32'h00A0_1800, 32'h4, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0),
            ve(32'h7, 32'h0, 32'h1800, 32'h4, 32'h00A0_1800, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0));
        add(vi(1'b1, 32'h00E0_0800, 32'h8, 1'b0, 1'b0, 1'b1, 5'd7, 32'h1234),
            ve(32'h1234, 32'h0, 32'h0800, 32'h8, 32'h00E0_0800, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0));
        add(vi(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF), bub(1'b0, 1'b0));
        add(vi(1'b1, 32'h0007_1000, 32'hC, 1'b0, 1'b0, 1'b1, 5'd0, 32'hDEAD),
            ve(32'h0, 32'h1234, 32'h1000, 32'hC, 32'h0007_1000, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0));
        // Load-use on rs: one stall cycle, one bubble, then the ADD
        add(vi(1'b1, 32'hE024_0008, 32'h10, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0),
            ve(32'h0, 32'h0, 32'h8, 32'h10, 32'hE024_0008, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0));
        add(vi(1'b1, 32'h0084_3000, 32'h14, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0), bub(1'b0, 1'b1));
        add(vi(1'b1, 32'h0084_3000, 32'h14, 1'b0, 1'b0, 1'b1, 5'd4, 32'h55),
            ve(32'h55, 32'h55, 32'h3000, 32'h14, 32'h0084_3000, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0));
        // LW then ADDI with r4 only as rt: no stall
        add(vi(1'b1, 32'hE024_0008, 32'h18, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0),
            ve(32'h0, 32'h55, 32'h8, 32'h18, 32'hE024_0008, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0));
        add(vi(1'b1, 32'h4044_0001, 32'h1C, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0),
            ve(32'h0, 32'h55, 32'h1, 32'h1C, 32'h4044_0001, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0));
        // Sign extension
        add(vi(1'b1, 32'h4002_FFFC, 32'h20, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0),
            ve(32'h0, 32'h0, 32'hFFFF_FFFC, 32'h20, 32'h4002_FFFC, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0));
        // Load-use through the rt source of SW
        add(vi(1'b1, 32'hE024_0008, 32'h24, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0),
            ve(32'h0, 32'h55, 32'h8, 32'h24, 32'hE024_0008, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0));
        add(vi(1'b1, 32'hE404_0010, 32'h28, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0), bub(1'b0, 1'b1));
        add(vi(1'b1, 32'hE404_0010, 32'h28, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0),
            ve(32'h0, 32'h55, 32'h10, 32'h28, 32'hE404_0010, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0));
        // Undefined opcode, then BEQZ r5
        add(vi(1'b1, 32'hA800_0000, 32'h2C, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0),
            ve(32'h0, 32'h0, 32'h0, 32'h2C, 32'hA800_0000, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0));
        add(vi(1'b1, 32'hD0A0_0000, 32'h30, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0),
            ve(32'h7, 32'h0, 32'h0, 32'h30, 32'hD0A0_0000, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0));
        // flush beats stall_in, then a 3-cycle hold
        add(vi(1'b1, 32'h00A0_1800, 32'h34, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0), bub(1'b0, 1'b1));
        add(vi(1'b1, 32'h00A0_1800, 32'h38, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0),
            ve(32'h7, 32'h0, 32'h1800, 32'h38, 32'h00A0_1800, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0));
        for (int k = 0; k < 3; k++)
            add(vi(1'b1, 32'h4002_FFFC, 32'h3C, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0),
                ve(32'h7, 32'h0, 32'h1800, 32'h38, 32'h00A0_1800, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1));
        // HLT is sticky and survives flush
        add(vi(1'b1, 32'hFC00_0000, 32'h40, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0),
            ve(32'h0, 32'h0, 32'h0, 32'h40, 32'hFC00_0000, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0));
        add(vi(1'b1, 32'h00A0_1800, 32'h44, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0), bub(1'b1, 1'b1));
        add(vi(1'b1, 32'h00A0_1800, 32'h48, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0), bub(1'b1, 1'b1));
        add(vi(1'b1, 32'h00A0_1800, 32'h4C, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0), bub(1'b1, 1'b1));

        // Reset state
        drive(vi(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0));
        #1;
        check_outs("reset", bub(1'b0, 1'b0));
        check("reset.stall_if", 32'(bus.stall_if), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int k = 0; k < tv.size(); k++) begin
            drive(tv[k].i);
            #1;
            check($sformatf("v%0d.stall_if", k), 32'(bus.stall_if), 32'(tv[k].e.stall_if));
            @(posedge clk);
            #1;
            check_outs($sformatf("v%0d", k), tv[k].e);
        end

        // Async reset while halted: stall_if follows stall_in during reset
        #3;
        bus.stall_in = 1'b1;
        rst = 1'b1;
        #1;
        check("rst_halt.halted", 32'(bus.halted), 32'd0);
        check("rst_halt.stall_if_hi", 32'(bus.stall_if), 32'd1);
        bus.stall_in = 1'b0;
        #1;
        check("rst_halt.stall_if_lo", 32'(bus.stall_if), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Register file was cleared: r5 reads 0
        drive(vi(1'b1, 32'h00A0_1800, 32'h4, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0));
        @(posedge clk);
        #1;
        check_outs("post_rst", ve(32'h0, 32'h0, 32'h1800, 32'h4, 32'h00A0_1800, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0));

        // Mid-cycle async reset clears a captured instruction at once
        #3;
        rst = 1'b1;
        #1;
        check_outs("mid_rst", bub(1'b0, 1'b0));
        #1;
        rst = 1'b0;

        // Reset in the middle of a load-use hazard drops the stall
        drive(vi(1'b1, 32'hE024_0008, 32'h8, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0));
        @(posedge clk);
        #1;
        drive(vi(1'b1, 32'h0084_3000, 32'hC, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0));
        #1;
        check("lu_rst.stall_before", 32'(bus.stall_if), 32'd1);
        rst = 1'b1;
        #1;
        check("lu_rst.stall_after", 32'(bus.stall_if), 32'd0);
        check("lu_rst.valid_id", 32'(bus.valid_id), 32'd0);
        #1;
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage MIPS32-style pipeline. Sits between IF and the execute stage.
- Holds the 32x32 register file, with the write port driven by WB. Decodes the instruction, reads operands and sign-extends the immediate.
- Detects load-use hazards and captures everything into the ID/EX pipeline register. That register drives the exe inputs A, B, Imm, NPC_id and IR_id.

Parameters:
- NOP_IR, 32'h0000_0000, bubble encoding: ADD r0,r0,r0 with we_id=0.
- HLT_OP, 6'b111111, halt opcode.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_if  in  1  IF/ID holds a real instruction.
- IR_if  in  32  instruction from IF.
- NPC_if  in  32  next PC from IF.
- stall_in  in  1  downstream hold; freeze the ID/EX register.
- flush  in  1  exe sel (taken branch); kill the instruction being captured.
- wb_en  in  1  writeback enable.
- wb_addr  in  5  writeback register.
- wb_data  in  32  writeback value.
- A  out  32  reg[rs].
- B  out  32  reg[rt].
- Imm  out  32  sign-extended IR[15:0].
- NPC_id  out  32  registered NPC.
- IR_id  out  32  registered instruction.
- valid_id  out  1  ID/EX slot holds a real instruction.
- dst_id  out  5  destination register.
- we_id  out  1  instruction writes dst_id.
- halted  out  1  HLT has been captured; sticky.
- stall_if  out  1  combinational; IF must hold IR_if/NPC_if this cycle.

Behaviour:
- Fields: opcode=IR[31:26], rs=IR[25:21], rt=IR[20:16], rd=IR[15:11].
- Opcode classes:
  - opcode[5]=0: ALU. opcode[4]=0 is RR (dst=rd); opcode[4]=1 is RImm (dst=rt). we=1.
  - LW=111000: dst=rt, we=1.
  - SW=111001: we=0, reads rt.
  - BEQZ=110100 / BNEQZ=110101: we=0.
  - HLT: we=0.
  - Undefined opcodes: captured as-is with we=0.
- rt is a source only for RR ALU ops and SW.
- Register file:
  - rst clears all 32 entries to 0.
  - Write on rising edge when wb_en=1 and wb_addr!=0; writes to r0 are ignored, and reads of r0 return 0.
  - Write-before-read bypass: when wb_en=1, wb_addr!=0 and wb_addr equals rs (or rt), A (or B) captures wb_data in that same cycle.
- Imm = {{16{IR_if[15]}}, IR_if[15:0]} for all opcodes.
- Load-use hazard (lu):
  - Condition: valid_id=1, IR_id opcode is LW, dst_id!=0, valid_if=1, and dst_id matches rs, or matches rt when rt is a source.
  - Effect: insert one bubble and hold IF.
  - MEM->EX forwarding is not done here.
- ID/EX register update at each rising edge, first match wins:
  1. flush=1: load bubble (IR_id=NOP_IR, valid_id=0, we_id=0, dst_id=0, A=B=Imm=0, NPC_id=0).
  2. stall_in=1: hold all outputs.
  3. halted=1, lu=1, or valid_if=0: load bubble.
  4. Otherwise: capture the decoded instruction with valid_id=1.
- stall_if = stall_in | lu | halted. flush takes priority over stall_if as seen by IF.
- halted:
  - Set when an HLT with valid_if=1 is captured under rule 4.
  - Cleared only by rst; ignores flush once set.
  - While halted, IR_if and NPC_if are ignored.
- Reset:
  - Async, takes effect immediately, including mid-stall or mid-hazard.
  - All outputs go to 0: IR_id=NOP_IR, valid_id=0, we_id=0, halted=0.
  - stall_if therefore follows stall_in during reset.
- Latency: 1 cycle from IR_if to IR_id/A/B/Imm.

Test Plan:
- Basic ALU: rst pulse; WB r5=32'h7; then IR_if=32'h00A0_1800 (ADD r3,r5,r0), NPC_if=32'h4 -> next cycle A=7, B=0, dst_id=3, we_id=1, NPC_id=4, valid_id=1.
- Bypass and r0 rules:
  - wb_en=1, wb_addr=7, wb_data=32'h1234 in the same cycle IR reads rs=7 -> A=32'h1234.
  - WB to r0 with 32'hFFFF -> later read of r0 gives 0.
- Load-use: LW r4,8(r1) (32'hE024_0008) then ADD r6,r4,r4 (32'h0084_3000):
  - stall_if=1 for exactly one cycle, one bubble (valid_id=0), then ADD with dst_id=6.
  - Also, ADDI (opcode 010000) using r4 only via rt -> no stall.
- Sign extension: ADDI with IR[15:0]=16'hFFFC, rt=2 -> Imm=32'hFFFF_FFFC, dst_id=2.
- flush vs stall: flush=1 with valid instruction and stall_in=1 -> bubble loaded, not held. stall_in=1 alone for 3 cycles -> outputs unchanged.
- HLT and reset:
  - HLT (32'hFC00_0000) captured -> halted=1, stall_if=1, subsequent cycles are bubbles. Flush does not clear halted.
  - Async rst mid-cycle -> all outputs 0 immediately.
